// File: rtl/speck_round_engine_if.sv
// Handshake bundle for the SPECK round engine: block in, subkey fetch, block out.
// The engine connects through "slave"; the block driving it uses "master".
interface speck_round_engine_if #(
  parameter int WORD_WIDTH = 16,
  parameter int MAX_ROUNDS = 22
);
  localparam int RCW = $clog2(MAX_ROUNDS + 1);

  logic                    mode;
  logic                    in_valid;
  logic                    in_ready;
  logic [2*WORD_WIDTH-1:0] in_block;
  logic [RCW-1:0]          in_rounds;
  logic                    key_req;
  logic [RCW-1:0]          key_idx;
  logic                    key_valid;
  logic [WORD_WIDTH-1:0]   key;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*WORD_WIDTH-1:0] out_block;

  modport master (
    output mode, in_valid, in_block, in_rounds, key_valid, key, out_ready,
    input  in_ready, key_req, key_idx, out_valid, out_block
  );

  modport slave (
    input  mode, in_valid, in_block, in_rounds, key_valid, key, out_ready,
    output in_ready, key_req, key_idx, out_valid, out_block
  );
endinterface

// File: rtl/speck_round_engine.sv
// Multi-round SPECK encrypt/decrypt datapath, one subkey fetched per round,
// each round split into two half-round cycles. One block in flight at a time.
module speck_round_engine #(
  parameter int WORD_WIDTH = 16,
  parameter int ALPHA      = 7,
  parameter int BETA       = 2,
  parameter int MAX_ROUNDS = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  speck_round_engine_if.slave   bus,
  output logic                  busy,
  output logic [2:0]            state_response
);
  localparam int RCW = $clog2(MAX_ROUNDS + 1);
  localparam logic [RCW-1:0] ONE   = RCW'(1);
  localparam logic [RCW-1:0] MAX_R = RCW'(MAX_ROUNDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ROUND_A = 3'd2,
    ROUND_B = 3'd3,
    DONE    = 3'd4
  } state_t;

  if (ALPHA < 1 || ALPHA > WORD_WIDTH - 1 || BETA < 1 || BETA > WORD_WIDTH - 1) begin : g_rot_check
    $error("speck_round_engine: ALPHA and BETA must lie in 1..WORD_WIDTH-1");
  end

  function automatic logic [WORD_WIDTH-1:0] ror(input logic [WORD_WIDTH-1:0] v, input int s);
    return (v >> s) | (v << (WORD_WIDTH - s));
  endfunction

  function automatic logic [WORD_WIDTH-1:0] rol(input logic [WORD_WIDTH-1:0] v, input int s);
    return (v << s) | (v >> (WORD_WIDTH - s));
  endfunction

  state_t                state, state_next;
  logic [WORD_WIDTH-1:0] x, y, k;
  logic [RCW-1:0]        r, n;
  logic                  dec;
  logic [RCW-1:0]        clamped;
  logic                  last_round;

  assign clamped    = (bus.in_rounds > MAX_R) ? MAX_R : bus.in_rounds;
  // Encrypt walks subkeys upward, decrypt walks them back down to index 0.
  assign last_round = dec ? (r == '0) : (r == n - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every register here is updated with <= so all right-hand sides see
  // the values from before the edge, e.g. ROUND_B's y uses x before x^k lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= '0;
      y   <= '0;
      k   <= '0;
      r   <= '0;
      n   <= '0;
      dec <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          x   <= bus.in_block[WORD_WIDTH-1:0];
          y   <= bus.in_block[2*WORD_WIDTH-1:WORD_WIDTH];
          dec <= bus.mode;
          n   <= clamped;
          r   <= bus.mode ? clamped - ONE : '0;
        end
        FETCH: if (bus.key_valid) k <= bus.key;
        ROUND_A: begin
          if (dec) y <= ror(x ^ y, BETA);
          else     x <= ror(x, ALPHA) + y;
        end
        ROUND_B: begin
          if (dec) begin
            x <= rol((x ^ k) - y, ALPHA);
          end else begin
            x <= x ^ k;
            y <= rol(y, BETA) ^ (x ^ k);
          end
          if (!last_round) r <= dec ? r - ONE : r + ONE;
        end
        default: ;
      endcase
    end
  end

  // NOTE: each output and state_next gets a default first so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next     = state;
    bus.in_ready   = 1'b0;
    bus.key_req    = 1'b0;
    bus.key_idx    = '0;
    bus.out_valid  = 1'b0;
    bus.out_block  = '0;
    busy           = (state != IDLE);
    state_response = state;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = (clamped == '0) ? DONE : FETCH;
      end
      FETCH: begin
        bus.key_req = 1'b1;
        bus.key_idx = r;
        if (bus.key_valid) state_next = ROUND_A;
      end
      ROUND_A: state_next = ROUND_B;
      ROUND_B: state_next = last_round ? DONE : FETCH;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_block = {y, x};
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_speck_round_engine.sv
// Randomised self-checking bench for speck_round_engine against a whole-round
// Speck32/64 reference model with its own key schedule.
module tb_speck_round_engine;
  localparam int W    = 16;
  localparam int MAXR = 22;
  localparam int RCW  = $clog2(MAXR + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [2:0] state_response;
  int         total = 0;
  int         bad = 0;
  logic [W-1:0] rk [MAXR];

  speck_round_engine_if #(.WORD_WIDTH(W), .MAX_ROUNDS(MAXR)) bus();

  speck_round_engine #(.WORD_WIDTH(W), .ALPHA(7), .BETA(2), .MAX_ROUNDS(MAXR)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .state_response(state_response)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ror16(input logic [15:0] v, input int s);
    logic [31:0] d;
    d = {v, v};
    return d[s +: 16];
  endfunction

  function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
    return ror16(v, 16 - s);
  endfunction

  task automatic gen_keys(input logic [63:0] mk);
    logic [15:0] l [MAXR + 2];
    logic [15:0] kk;
    kk   = mk[15:0];
    l[0] = mk[31:16];
    l[1] = mk[47:32];
    l[2] = mk[63:48];
    for (int i = 0; i < MAXR; i++) begin
      rk[i] = kk;
      l[i + 3] = (kk + ror16(l[i], 7)) ^ 16'(i);
      kk = rol16(kk, 2) ^ l[i + 3];
    end
  endtask

  function automatic logic [31:0] model(input bit dec, input logic [31:0] blk, input int rounds);
    int n;
    logic [15:0] x, y;
    n = (rounds > MAXR) ? MAXR : rounds;
    x = blk[15:0];
    y = blk[31:16];
    if (!dec) begin
      for (int i = 0; i < n; i++) begin
        x = (ror16(x, 7) + y) ^ rk[i];
        y = rol16(y, 2) ^ x;
      end
    end else begin
      for (int i = n - 1; i >= 0; i--) begin
        y = ror16(x ^ y, 2);
        x = rol16(16'((x ^ rk[i]) - y), 7);
      end
    end
    return {y, x};
  endfunction

  // Drives one block through the engine, serving keys (optionally stalled) and
  // holding off the output for bp cycles. Latency counts the accept cycle.
  task automatic run_block(input bit dec, input logic [31:0] blk, input logic [RCW-1:0] rounds,
                           input int stall_pct, input int bp,
                           output logic [31:0] res, output int lat, output int stalls);
    int n, seq, guard, ei;
    logic [31:0] held;
    n = (int'(rounds) > MAXR) ? MAXR : int'(rounds);
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL in_ready_wait: got %b expected 1", bus.in_ready);
    end
    bus.mode = dec; bus.in_block = blk; bus.in_rounds = rounds; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    seq = 0; stalls = 0; lat = 1;
    while (!bus.out_valid && lat < 400) begin
      bus.mode = 1'($urandom); bus.in_block = $urandom; bus.in_rounds = RCW'($urandom);
      if (bus.key_req) begin
        ei = dec ? n - 1 - seq : seq;
        if (ei < 0 || ei >= MAXR) ei = 0;
        total++;
        if (bus.key_idx !== RCW'(ei)) begin
          bad++; $display("FAIL key_idx: got %0d expected %0d (seq %0d)", bus.key_idx, ei, seq);
        end
        if ($urandom_range(99) < stall_pct) begin
          bus.key_valid = 1'b0; bus.key = W'($urandom); stalls++;
        end else begin
          bus.key_valid = 1'b1; bus.key = rk[ei]; seq++;
        end
      end else begin
        bus.key_valid = 1'($urandom); bus.key = W'($urandom);
      end
      @(posedge clk); #1; lat++;
    end
    bus.key_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL out_valid_timeout: got %b expected 1 after %0d cycles", bus.out_valid, lat);
    end
    total++;
    if (seq !== n) begin
      bad++; $display("FAIL key_count: got %0d expected %0d", seq, n);
    end
    res = bus.out_block;
    held = bus.out_block;
    for (int i = 0; i < bp; i++) begin
      bus.mode = 1'($urandom); bus.key_valid = 1'($urandom);
      @(posedge clk); #1;
      total++;
      if ({bus.out_valid, bus.in_ready, busy, bus.out_block} !== {1'b1, 1'b0, 1'b1, held}) begin
        bad++; $display("FAIL out_hold: got v=%b rdy=%b busy=%b blk=%h expected 1 0 1 %h",
                        bus.out_valid, bus.in_ready, busy, bus.out_block, held);
      end
    end
    bus.key_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++; $display("FAIL release: got out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    bus.key_valid = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus.in_ready, bus.key_req, bus.key_idx, bus.out_valid, bus.out_block, busy, state_response}
        !== {1'b1, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0}) begin
      bad++; $display("FAIL reset_state: rdy=%b req=%b idx=%0d ov=%b blk=%h busy=%b st=%0d expected 1 0 0 0 0 0 0",
                      bus.in_ready, bus.key_req, bus.key_idx, bus.out_valid, bus.out_block, busy, state_response);
    end
    bus.key_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus.in_ready, busy, state_response} !== {1'b1, 1'b0, 3'd0}) begin
      bad++; $display("FAIL reset_release_idle: rdy=%b busy=%b st=%0d expected 1 0 0", bus.in_ready, busy, state_response);
    end
  endtask

  task automatic test_single_round();
    logic [31:0] res; int lat, st;
    run_block(1'b0, 32'h694c_6574, RCW'(1), 0, 0, res, lat, st);
    total++;
    if (res !== 32'hf627_5316) begin bad++; $display("FAIL enc1_result: got %h expected f6275316", res); end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL enc1_latency: got %0d expected 4", lat); end
    run_block(1'b1, 32'hf627_5316, RCW'(1), 0, 0, res, lat, st);
    total++;
    if (res !== 32'h694c_6574) begin bad++; $display("FAIL dec1_result: got %h expected 694c6574", res); end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL dec1_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_full_rounds();
    logic [31:0] res; int lat, st;
    run_block(1'b0, 32'h694c_6574, RCW'(22), 0, 0, res, lat, st);
    total++;
    if (res !== 32'h42f2_a868) begin bad++; $display("FAIL enc22_result: got %h expected 42f2a868", res); end
    total++;
    if (lat !== 67) begin bad++; $display("FAIL enc22_latency: got %0d expected 67", lat); end
    run_block(1'b1, 32'h42f2_a868, RCW'(22), 0, 0, res, lat, st);
    total++;
    if (res !== 32'h694c_6574) begin bad++; $display("FAIL dec22_result: got %h expected 694c6574", res); end
    total++;
    if (lat !== 67) begin bad++; $display("FAIL dec22_latency: got %0d expected 67", lat); end
  endtask

  task automatic test_edge_counts();
    logic [31:0] res, blk; int lat, st;
    for (int m = 0; m < 2; m++) begin
      blk = $urandom;
      run_block(1'(m), blk, RCW'(0), 0, 2, res, lat, st);
      total++;
      if (res !== blk) begin bad++; $display("FAIL passthrough_result: mode %0d got %h expected %h", m, res, blk); end
      total++;
      if (lat !== 1) begin bad++; $display("FAIL passthrough_latency: got %0d expected 1", lat); end
    end
    run_block(1'b0, 32'h694c_6574, RCW'(31), 0, 0, res, lat, st);
    total++;
    if (res !== 32'h42f2_a868) begin bad++; $display("FAIL clamp_result: got %h expected 42f2a868", res); end
    total++;
    if (lat !== 67) begin bad++; $display("FAIL clamp_latency: got %0d expected 67", lat); end
  endtask

  task automatic test_stalls();
    logic [31:0] res; int lat, st;
    run_block(1'b0, 32'h694c_6574, RCW'(22), 40, 5, res, lat, st);
    total++;
    if (res !== 32'h42f2_a868) begin bad++; $display("FAIL stall_result: got %h expected 42f2a868", res); end
    total++;
    if (lat !== 67 + st) begin bad++; $display("FAIL stall_latency: got %0d expected %0d", lat, 67 + st); end
  endtask

  task automatic test_random();
    logic [31:0] res, blk, exp; int lat, st, rounds, n; bit dec;
    for (int i = 0; i < 10; i++) begin
      dec = 1'($urandom); blk = $urandom; rounds = $urandom_range(0, 31);
      n = (rounds > MAXR) ? MAXR : rounds;
      exp = model(dec, blk, rounds);
      run_block(dec, blk, RCW'(rounds), 25, $urandom_range(0, 3), res, lat, st);
      total++;
      if (res !== exp) begin bad++; $display("FAIL random_result[%0d]: got %h expected %h", i, res, exp); end
      total++;
      if (lat !== 3 * n + 1 + st) begin bad++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, 3 * n + 1 + st); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ct, pt, blk; int lat, st;
    for (int i = 0; i < 3; i++) begin
      blk = $urandom;
      run_block(1'b0, blk, RCW'(22), 0, 0, ct, lat, st);
      run_block(1'b1, ct, RCW'(22), 0, 0, pt, lat, st);
      total++;
      if (pt !== blk) begin bad++; $display("FAIL roundtrip[%0d]: got %h expected %h", i, pt, blk); end
    end
  endtask

  task automatic test_mid_reset();
    int seq, guard; logic [31:0] res; int lat, st; bit seen;
    bus.mode = 1'b0; bus.in_block = 32'h694c_6574; bus.in_rounds = RCW'(22); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    seq = 0; guard = 0;
    while (!(state_response == 3'd2 && seq == 5) && guard < 100) begin
      if (bus.key_req) begin bus.key_valid = 1'b1; bus.key = rk[seq]; seq++; end
      else bus.key_valid = 1'b0;
      @(posedge clk); #1; guard++;
    end
    total++;
    if (state_response !== 3'd2) begin bad++; $display("FAIL mid_reset_reach: got state %0d expected 2", state_response); end
    bus.key_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.in_ready, bus.key_req, bus.key_idx, bus.out_valid, bus.out_block, busy, state_response}
        !== {1'b1, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0}) begin
      bad++; $display("FAIL mid_reset_async: rdy=%b req=%b idx=%0d ov=%b blk=%h busy=%b st=%0d expected 1 0 0 0 0 0 0",
                      bus.in_ready, bus.key_req, bus.key_idx, bus.out_valid, bus.out_block, busy, state_response);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      bus.key_valid = 1'($urandom);
      @(posedge clk); #1;
      if (bus.out_valid || busy) seen = 1'b1;
    end
    bus.key_valid = 1'b0;
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL mid_reset_no_output: got activity=%b expected 0", seen); end
    run_block(1'b0, 32'h694c_6574, RCW'(22), 20, 1, res, lat, st);
    total++;
    if (res !== 32'h42f2_a868) begin bad++; $display("FAIL post_reset_result: got %h expected 42f2a868", res); end
  endtask

  initial begin
    bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_block = '0; bus.in_rounds = '0;
    bus.key_valid = 1'b0; bus.key = '0; bus.out_ready = 1'b0;
    gen_keys(64'h1918_1110_0908_0100);
    repeat (2) @(posedge clk);
    test_reset();
    test_single_round();
    test_full_rounds();
    test_edge_counts();
    test_stalls();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
